pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_stage_buf.sv | 111 +++++++++++
 tb/tb_pipe_stage_buf.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer (main + skid) between pipeline stages, 1-cycle latency.
// in_ready comes only from the state register, so no combinational path runs from out_ready to in_ready.
module pipe_stage_buf #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state, state_nxt;
  entry_t main_q, skid_q, in_ent;
  logic   accept, take;
  logic   load_main_in, load_main_skid, load_skid;

  assign in_ent    = '{ctrl: in_ctrl, data: in_data};
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign occ       = state;
  assign accept    = in_valid & in_ready;
  assign take      = out_valid & out_ready;
  assign out_ctrl  = out_valid ? main_q.ctrl : '0;
  assign out_data  = main_q.data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt    = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && !take) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (accept && take) begin
          load_main_in = 1'b1;
        end else if (take) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (take) begin
          state_nxt      = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush overrides every transition; payload loads are suppressed in the register block.
    if (flush) state_nxt = EMPTY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_q.ctrl <= '0;
      skid_q.ctrl <= '0;
    end else begin
      if (load_main_in)        main_q <= in_ent;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_ent;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bubble_cnt <= '0;
    else if (out_ready && !out_valid && !flush && (bubble_cnt != CNT_MAX))
      bubble_cnt <= bubble_cnt + CNT_ONE;
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed scenarios then random traffic, checked against a queue-based model of the stage.
module tb_pipe_stage_buf;
  localparam int CW = 16;
  localparam int DW = 32;
  localparam int NW = 4;
  localparam int CNT_MAX = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occ;
  logic [NW-1:0] bubble_cnt;

  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occ(occ), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] m_data;
  int            m_cnt;
  int            n_assert = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_data = '0;
    m_cnt  = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".occ"},        64'(occ),        64'(q.size()));
    chk({tag, ".in_ready"},   64'(in_ready),   64'(q.size() < 2));
    chk({tag, ".out_valid"},  64'(out_valid),  64'(q.size() > 0));
    chk({tag, ".out_ctrl"},   64'(out_ctrl),   64'((q.size() > 0) ? q[0].c : '0));
    chk({tag, ".out_data"},   64'(out_data),   64'(m_data));
    chk({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(m_cnt));
  endtask

  // One clock edge of the reference: a FIFO of depth two with flush, plus a saturating counter.
  task automatic model_edge();
    bit   acc, tk;
    ent_t e;
    acc = in_valid && (q.size() < 2);
    tk  = out_ready && (q.size() > 0);
    if (out_ready && (q.size() == 0) && !flush && (m_cnt < CNT_MAX)) m_cnt++;
    if (flush) begin
      q.delete();
    end else begin
      if (tk) void'(q.pop_front());
      if (acc) begin
        e.c = in_ctrl;
        e.d = in_data;
        q.push_back(e);
      end
    end
    if (q.size() > 0) m_data = q[0].d;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit iv, input logic [CW-1:0] ic, input bit ordy, input bit fl);
    in_valid  = iv;
    in_ctrl   = ic;
    in_data   = $urandom;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, '0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.out_data_zero", 64'(out_data), 64'(0));
    reset = 1'b0;

    for (int i = 1; i <= 8; i++) begin
      drive(1, CW'(i), 1, 0);
      step("stream");
      chk("stream.ctrl_seq", 64'(out_ctrl), 64'(i));
      chk("stream.occ_one", 64'(occ), 64'(1));
    end
    drive(0, '0, 1, 0);
    step("drain");

    drive(1, 16'h11, 0, 0);
    step("bp_a");
    drive(1, 16'h22, 0, 0);
    step("bp_b");
    chk("bp.full_occ", 64'(occ), 64'(2));
    chk("bp.full_ready", 64'(in_ready), 64'(0));
    drive(1, 16'h99, 0, 0);
    step("bp_hold");
    chk("bp.hold_ctrl", 64'(out_ctrl), 64'(16'h11));
    drive(0, '0, 1, 0);
    step("bp_rel1");
    chk("bp.second_ctrl", 64'(out_ctrl), 64'(16'h22));
    step("bp_rel2");
    chk("bp.empty_occ", 64'(occ), 64'(0));

    drive(1, 16'h01, 0, 0);
    step("fl_fill1");
    drive(1, 16'h02, 0, 0);
    step("fl_fill2");
    drive(1, 16'h33, 0, 1);
    step("flush");
    chk("flush.occ", 64'(occ), 64'(0));
    chk("flush.ctrl", 64'(out_ctrl), 64'(0));
    drive(0, '0, 1, 0);
    repeat (2) begin
      step("post_flush");
      chk("post_flush.no_c", 64'(out_valid), 64'(0));
    end

    drive(1, 16'h07, 1, 0);
    step("sim_load");
    drive(1, 16'h44, 1, 0);
    step("sim_acc_take");
    chk("sim.occ", 64'(occ), 64'(1));
    chk("sim.ctrl", 64'(out_ctrl), 64'(16'h44));

    drive(0, '0, 1, 0);
    repeat (20) step("sat");
    chk("sat.cnt", 64'(bubble_cnt), 64'(15));
    step("sat_nowrap");
    chk("sat.nowrap", 64'(bubble_cnt), 64'(15));

    drive(1, 16'h05, 0, 0);
    step("rst_fill1");
    drive(1, 16'h06, 0, 0);
    step("rst_fill2");
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("rst_mid");
    #1 reset = 1'b0;
    drive(1, 16'h55, 0, 0);
    step("rst_first");
    chk("rst.first_ctrl", 64'(out_ctrl), 64'(16'h55));

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), CW'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
